cam_cfg_sched: RTL

Sequencer and arbiter for the shared IIC/SCCB transaction engine used by the camera front end of the ball locator. After power-up it walks the camera configuration LUT from `LUT_START` to `LUT_SIZE`, issuing one write per entry. It retries NACKed writes and waits out the sensor soft-reset delay. Once configuration completes, it grants the engine to a runtime register-access port used for exposure and gain tweaks.

---
 rtl/cam_cfg_sched_if.sv | 38 +++
 rtl/cam_cfg_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cam_cfg_sched_if.sv
// rtl/cam_cfg_sched_if.sv - engine, user-port and status signals of the camera config sequencer
interface cam_cfg_sched_if;
    logic       en;
    logic       device_done;
    logic       iic_ack;
    logic       write_done;
    logic       read_done;
    logic [7:0] iic_rdata;
    logic [1:0] iic_cmd;
    logic       iic_sel_lut;
    logic [7:0] LUT_INDEX;
    logic [7:0] iic_addr;
    logic [7:0] iic_wdata;
    logic       usr_req;
    logic       usr_rw;
    logic [7:0] usr_addr;
    logic [7:0] usr_wdata;
    logic       usr_ack;
    logic [7:0] usr_rdata;
    logic       usr_err;
    logic       cfg_done;
    logic       cfg_err;
    logic       busy;

    modport master (
        input  en, device_done, iic_ack, write_done, read_done, iic_rdata,
        input  usr_req, usr_rw, usr_addr, usr_wdata,
        output iic_cmd, iic_sel_lut, LUT_INDEX, iic_addr, iic_wdata,
        output usr_ack, usr_rdata, usr_err, cfg_done, cfg_err, busy
    );

    modport slave (
        output en, device_done, iic_ack, write_done, read_done, iic_rdata,
        output usr_req, usr_rw, usr_addr, usr_wdata,
        input  iic_cmd, iic_sel_lut, LUT_INDEX, iic_addr, iic_wdata,
        input  usr_ack, usr_rdata, usr_err, cfg_done, cfg_err, busy
    );
endinterface

// File: rtl/cam_cfg_sched.sv
// rtl/cam_cfg_sched.sv - walks the camera config LUT through the IIC engine, then arbitrates runtime register access
module cam_cfg_sched #(
    parameter int LUT_START = 2,
    parameter int LUT_SIZE  = 170,
    parameter int RST_INDEX = 2,
    parameter int RST_DELAY = 100_000,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk_100M,
    input  logic            rst_n,
    cam_cfg_sched_if.master bus
);

    localparam int DW = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [7:0]    START_IDX  = 8'(LUT_START);
    localparam logic [7:0]    LAST_IDX   = 8'(LUT_SIZE);
    localparam logic [7:0]    SRST_IDX   = 8'(RST_INDEX);
    localparam logic [DW-1:0] DLY_LOAD   = DW'(RST_DELAY - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    typedef enum logic [2:0] {
        IDLE, CFG_WR, CFG_GAP, CFG_DLY, READY, USR_XFER, USR_GAP
    } state_t;

    state_t        state_q;
    logic [1:0]    cmd_q;
    logic          sel_lut_q;
    logic [7:0]    lut_index_q;
    logic [7:0]    iic_addr_q;
    logic [7:0]    iic_wdata_q;
    logic          usr_rw_q;
    logic          usr_ack_q;
    logic [7:0]    usr_rdata_q;
    logic          usr_err_q;
    logic          cfg_done_q;
    logic          cfg_err_q;
    logic          busy_q;
    logic [RW-1:0] retry_q;
    logic [DW-1:0] dly_q;

    logic wr_hit_d;
    logic rd_hit_d;
    logic usr_hit_d;
    logic at_last_d;

    // A done pulse only counts when it matches the command currently on the engine.
    always_comb begin
        wr_hit_d  = bus.write_done && (cmd_q == CMD_WR);
        rd_hit_d  = bus.read_done  && (cmd_q == CMD_RD);
        usr_hit_d = usr_rw_q ? rd_hit_d : wr_hit_d;
        at_last_d = (lut_index_q >= LAST_IDX);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_IDLE;
            sel_lut_q   <= 1'b1;
            lut_index_q <= START_IDX;
            iic_addr_q  <= 8'h00;
            iic_wdata_q <= 8'h00;
            usr_rw_q    <= 1'b0;
            usr_ack_q   <= 1'b0;
            usr_rdata_q <= 8'h00;
            usr_err_q   <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            retry_q     <= '0;
            dly_q       <= '0;
        end else begin
            usr_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en && bus.device_done) begin
                        state_q <= CFG_WR;
                        cmd_q   <= CMD_WR;
                        busy_q  <= 1'b1;
                    end
                end

                CFG_WR: begin
                    if (wr_hit_d) begin
                        cmd_q <= CMD_IDLE;
                        if (!bus.iic_ack && (lut_index_q == SRST_IDX)) begin
                            retry_q <= '0;
                            dly_q   <= DLY_LOAD;
                            state_q <= CFG_DLY;
                        end else if (bus.iic_ack && (retry_q < RETRY_MAX)) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= CFG_GAP;
                        end else begin
                            // Either acked, or NACKed with retries used up: move on.
                            retry_q <= '0;
                            if (bus.iic_ack)
                                cfg_err_q <= 1'b1;
                            if (at_last_d) begin
                                cfg_done_q <= 1'b1;
                                sel_lut_q  <= 1'b0;
                                busy_q     <= 1'b0;
                                state_q    <= READY;
                            end else begin
                                lut_index_q <= lut_index_q + 8'd1;
                                state_q     <= CFG_GAP;
                            end
                        end
                    end
                end

                CFG_GAP: begin
                    cmd_q   <= CMD_WR;
                    state_q <= CFG_WR;
                end

                CFG_DLY: begin
                    if (dly_q == '0) begin
                        if (at_last_d) begin
                            cfg_done_q <= 1'b1;
                            sel_lut_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= READY;
                        end else begin
                            lut_index_q <= lut_index_q + 8'd1;
                            cmd_q       <= CMD_WR;
                            state_q     <= CFG_WR;
                        end
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end

                READY: begin
                    if (bus.en && bus.usr_req) begin
                        usr_rw_q    <= bus.usr_rw;
                        iic_addr_q  <= bus.usr_addr;
                        iic_wdata_q <= bus.usr_wdata;
                        cmd_q       <= bus.usr_rw ? CMD_RD : CMD_WR;
                        busy_q      <= 1'b1;
                        state_q     <= USR_XFER;
                    end
                end

                USR_XFER: begin
                    if (usr_hit_d) begin
                        cmd_q     <= CMD_IDLE;
                        usr_ack_q <= 1'b1;
                        usr_err_q <= bus.iic_ack;
                        if (usr_rw_q)
                            usr_rdata_q <= bus.iic_rdata;
                        state_q   <= USR_GAP;
                    end
                end

                USR_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= READY;
                end

                default: begin
                    cmd_q   <= CMD_IDLE;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.iic_cmd     = cmd_q;
    assign bus.iic_sel_lut = sel_lut_q;
    assign bus.LUT_INDEX   = lut_index_q;
    assign bus.iic_addr    = iic_addr_q;
    assign bus.iic_wdata   = iic_wdata_q;
    assign bus.usr_ack     = usr_ack_q;
    assign bus.usr_rdata   = usr_rdata_q;
    assign bus.usr_err     = usr_err_q;
    assign bus.cfg_done    = cfg_done_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.busy        = busy_q;

endmodule
